// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the six-digit millisecond countdown timer.
// Digit layout matches the existing millisecond timer and hex driver.
package countdown_timer_pkg;

    localparam int unsigned DIGIT_W         = 5;
    localparam int unsigned NUM_DIGITS      = 6;
    localparam int unsigned TIME_W          = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CLK_DIV_DEFAULT = 50000;

    typedef logic [DIGIT_W-1:0]          digit_t;
    typedef digit_t [NUM_DIGITS-1:0]     bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam digit_t DIGIT_MAX = DIGIT_W'(9);

    // Saturate every digit field to 9 so bit 4 is never set downstream.
    function automatic bcd_time_t clamp_time(input bcd_time_t t);
        bcd_time_t r;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            r[i] = (t[i] > DIGIT_MAX) ? DIGIT_MAX : t[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the countdown timer and its user.
interface countdown_timer_if;
    import countdown_timer_pkg::*;

    logic      load;
    bcd_time_t loadTime;
    logic      start;
    logic      pause;
    bcd_time_t timeOut;
    logic      running;
    logic      done;
    logic      expired;

    modport master (
        output load, loadTime, start, pause,
        input  timeOut, running, done, expired
    );

    modport slave (
        input  load, loadTime, start, pause,
        output timeOut, running, done, expired
    );

endinterface

// File: rtl/countdown_timer_bcd_dec_digit.sv
// One decimal digit of the ripple-borrow decrementer: 0 underflows to 9.
module bcdDecDigit
    import countdown_timer_pkg::*;
(
    input  digit_t digit,
    input  logic   borrowIn,
    output digit_t digitDec,
    output logic   borrowOut
);

    always_comb begin
        digitDec  = digit;
        borrowOut = 1'b0;
        if (borrowIn) begin
            if (digit == '0) begin
                digitDec  = DIGIT_MAX;
                borrowOut = 1'b1;
            end else begin
                digitDec = digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Six-digit decimal millisecond countdown timer with load/start/pause control.
// All outputs come straight from flops; the decrementer chain feeds next-state only.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic               clkIn,
    input  logic               resetN,
    countdown_timer_if.slave   bus
);

    localparam int unsigned     PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    bcd_time_t            time_q, time_d;
    bcd_time_t            dec_time;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 expired_q, expired_d;
    logic [NUM_DIGITS:0]  borrow;
    logic                 time_zero;
    logic                 dec_zero;

    // Borrow out of the top digit means the current value is already zero.
    assign borrow[0] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcdDecDigit u_digit (
            .digit     (time_q[g]),
            .borrowIn  (borrow[g]),
            .digitDec  (dec_time[g]),
            .borrowOut (borrow[g+1])
        );
    end

    assign time_zero = borrow[NUM_DIGITS];
    assign dec_zero  = (dec_time == '0);

    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            running_q <= running_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        time_d    = time_q;
        expired_d = 1'b0;

        if (bus.load) begin
            time_d  = clamp_time(bus.loadTime);
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (!bus.pause && bus.start) begin
                        if (time_zero) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        // Zero is unreachable in RUN, but never underflow if it were.
                        if (!time_zero) begin
                            time_d = dec_time;
                            if (dec_zero) begin
                                state_d   = ST_DONE;
                                expired_d = 1'b1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    assign bus.timeOut = time_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;

endmodule
